// File: rtl/satacc_block.sv
// satacc_block: accumulates LEN valid samples with per-block latched saturating/wrapping add mode
module satacc_block #(
  parameter int WIDTH = 12,
  parameter int LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
  logic [WIDTH-1:0] acc, r, res;
  logic [WIDTH:0] s;
  logic [CW-1:0] cnt;
  logic [1:0] mode_q, m;
  logic sticky, c, v, ev, last;
  always_comb begin
    m = cnt == '0 ? mode : mode_q;
    s = {1'b0, acc} + {1'b0, in_data};
    r = s[WIDTH-1:0];
    c = s[WIDTH];
    v = (acc[WIDTH-1] == in_data[WIDTH-1]) && (r[WIDTH-1] != acc[WIDTH-1]);
    res = m == 2'b00 ? (c ? '1 : r) :
          m == 2'b01 ? (v ? {acc[WIDTH-1], {(WIDTH-1){~acc[WIDTH-1]}}} : r) : r;
    ev = m == 2'b00 ? c : m == 2'b01 ? v : 1'b0;
    last = cnt == CW'(LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      mode_q <= '0;
      sticky <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (cnt == '0) mode_q <= mode;
        if (last) begin
          out_data <= res;
          out_sat <= sticky | ev;
          out_valid <= 1'b1;
          acc <= '0;
          cnt <= '0;
          sticky <= 1'b0;
        end else begin
          acc <= res;
          cnt <= cnt + 1'b1;
          sticky <= sticky | ev;
        end
      end
    end
  end
endmodule

// File: tb/tb_satacc_block.sv
// tb_satacc_block: directed plan plus random traffic against an integer-arithmetic reference
module tb_satacc_block;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clear = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [11:0] in_data = '0;
  logic ov4, os4, ov1, os1;
  logic [11:0] od4, od1;
  int errors = 0, checks = 0;
  int macc = 0, mcnt = 0, mmode = 0, mst = 0;
  int ev = 0, ed = 0, es = 0, ev1 = 0, ed1 = 0;

  satacc_block #(.WIDTH(12), .LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .clear(clear), .out_valid(ov4), .out_data(od4), .out_sat(os4));
  satacc_block #(.WIDTH(12), .LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .clear(clear), .out_valid(ov1), .out_data(od1), .out_sat(os1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int a, input int d, input int md, output int res, output int sat);
    int t, sa, sd;
    sat = 0;
    if (md == 0) begin
      t = a + d;
      res = t > 4095 ? 4095 : t;
      sat = t > 4095;
    end else if (md == 1) begin
      sa = a >= 2048 ? a - 4096 : a;
      sd = d >= 2048 ? d - 4096 : d;
      t = sa + sd;
      if (t > 2047) begin res = 2047; sat = 1; end
      else if (t < -2048) begin res = 2048; sat = 1; end
      else res = t & 4095;
    end else res = (a + d) % 4096;
  endtask

  task automatic cyc(input bit v, input int d, input bit clr, input int md, input bit rn);
    int res, sat, mu;
    mode = 2'(md); in_valid = v; in_data = 12'(d); clear = clr; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      macc = 0; mcnt = 0; mmode = 0; mst = 0; ev = 0; ed = 0; es = 0; ev1 = 0; ed1 = 0;
    end else if (clr) begin
      macc = 0; mcnt = 0; mst = 0; ev = 0; ev1 = 0;
    end else begin
      ev = 0; ev1 = v;
      if (v) begin
        ed1 = d;
        mu = mcnt == 0 ? md : mmode;
        if (mcnt == 0) mmode = md;
        add(macc, d, mu, res, sat);
        if (mcnt == 3) begin
          ed = res; es = mst | sat; ev = 1; macc = 0; mcnt = 0; mst = 0;
        end else begin
          macc = res; mcnt++; mst |= sat;
        end
      end
    end
    #1;
    chk("valid4", int'(ov4), ev);
    chk("data4", int'(od4), ed);
    chk("sat4", int'(os4), es);
    chk("valid1", int'(ov1), ev1);
    chk("data1", int'(od1), ed1);
    chk("sat1", int'(os1), 0);
  endtask

  task automatic blk(input int md, input int d0, input int d1, input int d2, input int d3);
    cyc(1, d0, 0, md, 1); cyc(1, d1, 0, md, 1); cyc(1, d2, 0, md, 1); cyc(1, d3, 0, md, 1);
  endtask

  task automatic expect_out(input string tag, input int d, input int s);
    chk({tag, "_v"}, int'(ov4), 1);
    chk({tag, "_d"}, int'(od4), d);
    chk({tag, "_s"}, int'(os4), s);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    chk("rst_v", int'(ov4), 0); chk("rst_d", int'(od4), 0); chk("rst_s", int'(os4), 0);
    blk(0, 'h500, 'h500, 'h500, 'h500); expect_out("uns", 'hFFF, 1);
    cyc(0, 0, 0, 0, 1); chk("pulse_one", int'(ov4), 0); chk("hold", int'(od4), 'hFFF);
    blk(1, 'h400, 'h400, 'h400, 'h400); expect_out("spos", 'h7FF, 1);
    blk(1, 'hC00, 'hC00, 'hC00, 'hC00); expect_out("sneg", 'h800, 1);
    blk(1, 'h001, 'h002, 'hFFF, 'h000); expect_out("snone", 'h002, 0);
    blk(2, 'h500, 'h500, 'h500, 'h500); expect_out("wrap", 'h400, 0);
    cyc(1, 'h800, 0, 0, 1); cyc(1, 'h800, 0, 1, 1); cyc(1, 0, 0, 1, 1); cyc(1, 0, 0, 1, 1);
    expect_out("latch", 'hFFF, 1);
    cyc(1, 'h100, 0, 0, 1); cyc(1, 'h100, 0, 0, 1); cyc(1, 'h100, 1, 0, 1);
    chk("clr_v", int'(ov4), 0); chk("clr_hold", int'(od4), 'hFFF);
    blk(0, 1, 1, 1, 1); expect_out("postclr", 'h004, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 'h010, 0, 0, 1);
      if (i < 3) for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, 1);
    end
    expect_out("gaps", 'h040, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 1);
      chk("b2b_v", int'(ov4), int'(i % 4 == 3));
    end
    cyc(1, 'h123, 0, 0, 1); cyc(1, 'h123, 0, 0, 1); cyc(0, 0, 0, 0, 0);
    chk("mrst_v", int'(ov4), 0); chk("mrst_d", int'(od4), 0); chk("mrst_s", int'(os4), 0);
    chk("mrst_d1", int'(od1), 0);
    blk(0, 2, 3, 4, 5); expect_out("fresh", 'h00E, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(9, 0) < 7, $urandom_range(4095, 0), $urandom_range(19, 0) == 0,
          $urandom_range(3, 0), $urandom_range(49, 0) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/satacc_block.md
# satacc_block

Parametrised saturating block accumulator, the sequential successor to the 12-bit combinational saturating adder. It sums `LEN` consecutive valid samples into a `WIDTH`-bit accumulator. Each partial sum uses unsigned saturation, signed saturation or wrapping addition, using the same mode encoding as the adder. After each block it presents the total, with a sticky saturation flag, for one cycle. It sits between a sample source and downstream consumers that need per-block sums.

## Interface

- `WIDTH`, 12: sample, accumulator and result width; ≥ 2.
- `LEN`, 16: samples per block; ≥ 1. Counter width is `$clog2(LEN)`, minimum 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  2  addition mode:
  - 00: unsigned saturation.
  - 01: signed saturation.
  - 10 or 11: wrapping addition.
- `in_valid`  in  1  `in_data` is valid this cycle. Always accepted; there is no back-pressure.
- `in_data`  in  `WIDTH`  sample.
- `clear`  in  1  synchronous abort of the current block.
- `out_valid`  out  1  one-cycle pulse; `out_data` and `out_sat` hold a new block result.
- `out_data`  out  `WIDTH`  block result; held until the next block completes.
- `out_sat`  out  1  a saturation occurred within that block; held with `out_data`.

## Operation

- **State:**
  - `acc` (`WIDTH` bits).
  - `cnt` (0..`LEN`-1).
  - `mode_q` (2 bits).
  - `sticky` (1 bit).
  - the registered outputs.
- **Mode latch:** on an accepted sample with `cnt` = 0, that sample uses `mode` directly and `mode_q` ← `mode`. Samples with `cnt` > 0 use `mode_q`. Changes to `mode` mid-block are ignored.
- **Sum:** s = {0,acc} + {0,in_data}, `WIDTH`+1 bits. r = s[`WIDTH`-1:0]. Let c = s[`WIDTH`].
- **Signed overflow:** v = (acc sign == in_data sign) && (r sign != acc sign).
- **Result per mode:**
  - 00: c=1 → all ones; otherwise r.
  - 01: v=1 with positive operands → 0111…1; v=1 with negative operands → 1000…0; otherwise r.
  - 1x: r, and the saturation event is forced to 0.
- **Accumulate:** the saturated value is the new `acc`, so the next addition starts from the clamp. `sticky` ← `sticky` | event.
- **Accepted sample with `cnt` < `LEN`-1:** `acc` ← result; `cnt` ← `cnt`+1.
- **Accepted sample with `cnt` = `LEN`-1:**
  - `out_data` ← result.
  - `out_sat` ← `sticky` | event.
  - `out_valid` ← 1.
  - `acc`, `cnt` and `sticky` ← 0.
- **LEN = 1:** every accepted sample completes a block; result = 0 + `in_data`, which never saturates.
- **`in_valid` = 0:** no state change, except that `out_valid` ← 0.
- **`clear` = 1:**
  - `acc`, `cnt` and `sticky` ← 0; `out_valid` ← 0.
  - `out_data` and `out_sat` are unchanged.
  - `clear` has priority: a simultaneous `in_valid` sample is discarded.
- **Reset (`rst_n` = 0 at an edge):** all state and every output ← 0, i.e. `out_valid` = 0, `out_data` = 0, `out_sat` = 0. Reset has priority over `clear` and `in_valid`. A mid-block reset discards the partial block.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- **Latency:** `out_valid` is high in the cycle immediately after the edge that captures the `LEN`-th accepted sample, for exactly one cycle.
- **Back-to-back:** a sample on the very next cycle starts the following block. With continuous `in_valid`, pulses arrive every `LEN` cycles with no dead cycles.
- Gaps in `in_valid` stretch a block. They never drop state.
- **Arithmetic width:** one `WIDTH`+1-bit adder plus clamp muxes in one cycle. No internal pipeline stage.

## Test plan

All scenarios use `WIDTH`=12 and `LEN`=4 unless stated.

1. **Unsigned saturation.** Reset, then mode 00 with 0x500 ×4 back-to-back.
   - Partial `acc`: 0x500, 0xA00, 0xF00, then 0xFFF (saturated).
   - One cycle after the 4th sample: `out_valid`=1, `out_data`=0xFFF, `out_sat`=1.
2. **Signed saturation.** Mode 01 with 0x400 ×4 → `out_data`=0x7FF, `out_sat`=1. A following block of 0xC00 ×4 → `out_data`=0x800, `out_sat`=1. Also run a signed block 0x001, 0x002, 0xFFF, 0x000 → 0x002, `out_sat`=0.
3. **Wrapping and mode latch.**
   - Mode 10 with 0x500 ×4 → `out_data`=0x400, `out_sat`=0.
   - Start a block in mode 00, switch `mode` to 01 after sample 1, then feed 0x800, 0x800, 0x000, 0x000 → unsigned clamp: `out_data`=0xFFF, `out_sat`=1.
4. **Clear mid-block.** Feed 0x100 ×2, then `clear`=1 together with `in_valid`=1 and data 0x100. Then feed 0x001 ×4 → `out_data`=0x004, `out_sat`=0. The previous `out_data` is held until then.
5. **Gaps and back-to-back blocks.**
   - 0x010 ×4 with `in_valid` low for 3 cycles between samples → one pulse, `out_data`=0x040.
   - Then 8 continuous samples of 0x001 → pulses exactly 4 cycles apart, each `out_data`=0x004.
6. **Reset behaviour.**
   - Assert `rst_n`=0 after 2 samples of a block → every output is 0. A fresh 4-sample block then completes normally.
   - Repeat with `LEN`=1: every sample gives a pulse with `out_data` = `in_data`.
